// File: rtl/sn74_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sn74_bus_arbiter_if
// Description : Signal bundle between the round-robin bus arbiter and the
//               requesters / SN74 mux select and output-disable pins.
//               master : arbiter side (samples req/lock, drives grant/sel/oe/busy)
//               slave  : requester side (drives req/lock, observes the rest)
//               Optional macro: SN74_ARB_LOCK_EN adds the tenure lock input.
// Ports       : req[NREQ]   request per requester, level-held
//               lock        tenure lock (SN74_ARB_LOCK_EN only)
//               grant[NREQ] one-hot grant
//               sel[SELW]   binary owner index for the mux select pins
//               oe          mux output disable, 1 = bus high-Z
//               busy        arbiter in a grant or turnaround phase
// Revision    : 1.0 - initial release
// ============================================================================
interface sn74_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int SELW = $clog2(NREQ)
);
  logic [NREQ-1:0] req;
`ifdef SN74_ARB_LOCK_EN
  logic            lock;
`endif
  logic [NREQ-1:0] grant;
  logic [SELW-1:0] sel;
  logic            oe;
  logic            busy;

`ifdef SN74_ARB_LOCK_EN
  modport master (input req, input lock, output grant, output sel, output oe, output busy);
  modport slave  (output req, output lock, input grant, input sel, input oe, input busy);
`else
  modport master (input req, output grant, output sel, output oe, output busy);
  modport slave  (output req, input grant, input sel, input oe, input busy);
`endif
endinterface
`default_nettype wire

// File: rtl/sn74_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sn74_bus_arbiter
// Description : Round-robin arbiter and sequencer for a shared bus built from
//               SN74XX253/257 tri-state multiplexers. Only one requester owns
//               the bus at a time; every hand-over passes through TURN
//               tri-stated cycles, and an owner is preempted after MAXHOLD
//               cycles when someone else is waiting.
//               Optional macro: SN74_ARB_LOCK_EN - adds a lock input that
//               suppresses MAXHOLD preemption while asserted in GRANT.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               bus.req    request vector (in)
//               bus.lock   tenure lock (in, SN74_ARB_LOCK_EN only)
//               bus.grant  one-hot grant (out, registered)
//               bus.sel    owner index to mux select (out, registered)
//               bus.oe     mux output disable, 1 = high-Z (out, registered)
//               bus.busy   1 in GRANT or TURN (out, registered)
// Parameters  : NREQ 2..8, SELW = $clog2(NREQ), MAXHOLD >= 2, TURN >= 1
// Revision    : 1.0 - initial release
// ============================================================================
module sn74_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int SELW    = $clog2(NREQ),
  parameter int MAXHOLD = 16,
  parameter int TURN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  sn74_bus_arbiter_if.master bus
);

  localparam int CNTW = $clog2(MAXHOLD);
  localparam int TW   = (TURN > 1) ? $clog2(TURN) : 1;

  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(MAXHOLD - 1);
  localparam logic [TW-1:0]   TURN_LAST = TW'(TURN - 1);
  // Pointer starts at the last requester so that req[0] wins first.
  localparam logic [SELW-1:0] PTR_RST   = SELW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [SELW-1:0] sel_q;
  logic            oe_q;
  logic            busy_q;
  logic [CNTW-1:0] cnt_q;
  logic [SELW-1:0] ptr_q;
  logic [TW-1:0]   tcnt_q;

  // Round-robin candidate and the one-hot grant it would produce.
  logic            pick_vld;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] cand;
  logic [NREQ-1:0] grant_d;

  logic            owner_req;
  logic            others_req;
  logic            at_max;
  logic            preempt_ok;
  logic            release_now;

  // --------------------------------------------------------------------------
  // Round-robin search: first set request strictly after the pointer,
  // wrapping past NREQ-1. The pointer itself is visited last, so a former
  // owner only wins again when nobody else is asking.
  // --------------------------------------------------------------------------
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = SELW'((int'(ptr_q) + k) % NREQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    grant_d           = '0;
    grant_d[pick_idx] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Release decision while owning the bus. sel_q holds the owner index and
  // grant_q is its one-hot mask, so "others" excludes the owner directly.
  // A dropped request and a preemption in the same cycle both land on the
  // same single release.
  // --------------------------------------------------------------------------
  always_comb begin
    owner_req  = bus.req[sel_q];
    others_req = |(bus.req & ~grant_q);
    at_max     = (cnt_q == CNT_MAX);
`ifdef SN74_ARB_LOCK_EN
    preempt_ok = !bus.lock;
`else
    preempt_ok = 1'b1;
`endif
    release_now = !owner_req || (at_max && others_req && preempt_ok);
  end

  // --------------------------------------------------------------------------
  // Sequencer. All outputs are registered here so the mux pins never see
  // combinational glitches; grant and oe always move together, keeping the
  // bus either driven by exactly one owner or fully tri-stated.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_GRANT;
            grant_q <= grant_d;
            sel_q   <= pick_idx;
            oe_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        ST_GRANT: begin
          if (release_now) begin
            state_q <= ST_TURN;
            grant_q <= '0;
            oe_q    <= 1'b1;
            ptr_q   <= sel_q;
            tcnt_q  <= '0;
          end else if (!at_max) begin
            // Saturating tenure counter: once at the limit it stays there
            // so a late-arriving requester preempts on its first cycle.
            cnt_q <= cnt_q + CNTW'(1);
          end
        end

        ST_TURN: begin
          if (tcnt_q == TURN_LAST) begin
            // Requests are only sampled on the final gap cycle, so pulses
            // that come and go earlier in the gap have no effect.
            if (pick_vld) begin
              state_q <= ST_GRANT;
              grant_q <= grant_d;
              sel_q   <= pick_idx;
              oe_q    <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end

        default: begin
          // Unreachable encoding: park the bus safely.
          state_q <= ST_IDLE;
          grant_q <= '0;
          oe_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.oe    = oe_q;
  assign bus.busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sn74_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sn74_bus_arbiter
// Description : Self-checking bench for sn74_bus_arbiter (NREQ=4, MAXHOLD=16,
//               TURN=1). Directed bus scenarios followed by randomized request
//               traffic, compared every cycle against a behavioural model of
//               owner / tenure / gap bookkeeping. Honours SN74_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sn74_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int SELW    = 2;
  localparam int MAXHOLD = 16;
  localparam int TURN    = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   lock_v = 1'b0;

  sn74_bus_arbiter_if #(.NREQ(NREQ), .SELW(SELW)) bus ();

`ifdef SN74_ARB_LOCK_EN
  assign bus.lock = lock_v;
`endif

  sn74_bus_arbiter #(
    .NREQ   (NREQ),
    .SELW   (SELW),
    .MAXHOLD(MAXHOLD),
    .TURN   (TURN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who owns the bus, how long they have held it, how many
  // tri-stated gap cycles remain, and whom the rotation last served.
  // --------------------------------------------------------------------------
  int m_owner;   // -1 when nobody owns the bus
  int m_held;    // cycles of grant shown so far for the current owner
  int m_gap;     // remaining turnaround cycles still to be shown
  int m_last;    // last served requester (rotation origin)
  int m_sel;

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = NREQ - 1;
    m_sel   = 0;
  endtask

  task automatic take_bus(input logic [NREQ-1:0] r);
    int w;
    w = rr_next(r, m_last);
    if (w >= 0) begin
      m_owner = w;
      m_sel   = w;
      m_held  = 1;
    end
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input bit l);
    bit others;
    bit lk;
`ifdef SN74_ARB_LOCK_EN
    lk = l;
`else
    lk = 1'b0;
`endif
    if (m_owner >= 0) begin
      others = (r & ~(NREQ'(1) << m_owner)) != '0;
      if (!r[m_owner] || (m_held >= MAXHOLD && others && !lk)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = TURN;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        take_bus(r);
      end else begin
        m_gap--;
      end
    end else begin
      take_bus(r);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [NREQ-1:0] eg;
    eg = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    chk({ctx, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({ctx, ".sel"},   32'(bus.sel),   32'(m_sel));
    chk({ctx, ".oe"},    32'(bus.oe),    32'(m_owner < 0));
    chk({ctx, ".busy"},  32'(bus.busy),  32'((m_owner >= 0) || (m_gap > 0)));
  endtask

  // Called at a negedge; leaves the bench at the next negedge.
  task automatic cycle(input logic [NREQ-1:0] r, input string ctx);
    bus.req = r;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(r, lock_v);
    #1 check_outputs(ctx);
    @(negedge clk);
  endtask

  // Reset asserted between edges: outputs must go safe immediately.
  task automatic async_reset(input string ctx);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs({ctx, ".async"});
    @(posedge clk);
    #1 check_outputs({ctx, ".held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [NREQ-1:0] rq;
  int              rc;
  bit              found;

  initial begin
    bus.req = '0;
    model_reset();

    // Reset before any clock edge.
    #2 rst = 1'b1;
    #1 check_outputs("reset0");
    @(negedge clk);
    rst = 1'b0;

    // Single requester: one-cycle latency, one gap cycle, then idle.
    cycle(4'b0000, "sc2_idle");
    for (int i = 0; i < 4; i++) cycle(4'b0100, "sc2_grant");
    for (int i = 0; i < 4; i++) cycle(4'b0000, "sc2_release");

    // Everybody asking: 0,1,2,3,0 each for MAXHOLD cycles with one gap cycle.
    async_reset("sc3");
    for (int i = 0; i < 5 * (MAXHOLD + TURN) + 3; i++) cycle(4'b1111, "sc3_rr");
    for (int i = 0; i < 3; i++) cycle(4'b0000, "sc3_drain");

    // Lone owner keeps the bus; a late requester preempts a saturated tenure.
    for (int i = 0; i < 40; i++) cycle(4'b0010, "sc4_alone");
    for (int i = 0; i < 24; i++) cycle(4'b1010, "sc4_preempt");
    for (int i = 0; i < 3; i++) cycle(4'b0000, "sc4_drain");

    // Reset during owner 2's tenure; rotation restarts from requester 0.
    async_reset("sc5_pre");
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(4'b1111, "sc5_run");
      if (m_owner == 2) found = 1'b1;
    end
    chk("sc5_reached_owner2", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) cycle(4'b1111, "sc5_run2");
    async_reset("sc5");
    for (int i = 0; i < 6; i++) cycle(4'b1111, "sc5_after");
    for (int i = 0; i < 3; i++) cycle(4'b0000, "sc5_drain");

`ifdef SN74_ARB_LOCK_EN
    // Locked owner is never preempted; dropping lock preempts at once.
    for (int i = 0; i < 3; i++) cycle(4'b0010, "sc6_take");
    lock_v = 1'b1;
    for (int i = 0; i < 50; i++) cycle(4'b0011, "sc6_locked");
    lock_v = 1'b0;
    for (int i = 0; i < 6; i++) cycle(4'b0011, "sc6_unlocked");
    for (int i = 0; i < 3; i++) cycle(4'b0000, "sc6_drain");
`endif

    // Randomized traffic in several density modes with occasional resets.
    rq = '0;
    for (int mode = 0; mode < 4; mode++) begin
      for (int i = 0; i < 500; i++) begin
        case (mode)
          0: rq = NREQ'($urandom);
          1: begin
            for (int b = 0; b < NREQ; b++)
              if ($urandom_range(23, 0) == 0) rq[b] = ~rq[b];
          end
          2: begin
            rc = $urandom_range(NREQ + 2, 0);
            rq = (rc < NREQ) ? (NREQ'(1) << rc) : '0;
          end
          default: rq = ($urandom_range(7, 0) == 0) ? NREQ'($urandom) : 4'b1111;
        endcase
`ifdef SN74_ARB_LOCK_EN
        if ($urandom_range(15, 0) == 0) lock_v = ~lock_v;
`endif
        if ($urandom_range(299, 0) == 0) async_reset("rnd");
        cycle(rq, "rnd");
      end
    end
    lock_v = 1'b0;
    for (int i = 0; i < 4; i++) cycle(4'b0000, "final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
